signed_prod_accum: RTL and testbench
====================================

// Module: signed_prod_accum
// PURPOSE
//  Downstream stage of the 10x10 signed multiplier. Accepts its 20-bit two's-complement
//  products over a valid/ready handshake and sums NUM_TERMS consecutive products into one
//  signed result (dot-product / FIR tap sum). Saturates on overflow and holds the result
//  until the consumer accepts it.
// PARAMETERS
//  PROD_W     20  width of incoming signed product (matches multiplier output)
//  ACC_W      24  width of accumulator and result; must be >= PROD_W
//  NUM_TERMS  8   products summed per frame; legal range 1..256
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-high reset
//  clr        in   1       synchronous frame abort / clear
//  prod_in    in   PROD_W  signed product from multiplier
//  in_valid   in   1       prod_in is valid
//  in_ready   out  1       block accepts prod_in this cycle
//  acc_out    out  ACC_W   signed frame sum, registered
//  out_valid  out  1       acc_out holds a completed frame
//  out_ready  in   1       consumer takes acc_out
//  sat        out  1       sticky: saturation occurred in the frame now on acc_out
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-high (clk, rst).
//   Async assert -> state=ACCUM, acc=0, term count=0, acc_out=0, out_valid=0, sat=0.
//   Combinationally in_ready=1 (state ACCUM) from reset onward.
//  FSM: two states.
//   ACCUM: in_ready=1, out_valid=0. in_valid&&in_ready at an edge -> acc += sext(prod_in),
//    count++. On the NUM_TERMS-th accepted product -> load acc_out with the final sum,
//    out_valid=1, count=0, acc=0, go to DONE. No cycle with in_valid=0 advances count.
//   DONE: in_ready=0, out_valid=1, acc_out/sat stable. out_valid&&out_ready at an edge ->
//    out_valid=0, sat=0, go to ACCUM. Held indefinitely while out_ready=0.
//  Latency: out_valid rises on the edge that accepts the last term (0 extra cycles);
//   in_ready returns the cycle after the output handshake. Min frame period = NUM_TERMS+1.
//  Arithmetic: prod_in sign-extended to ACC_W+1; sum computed in ACC_W+1 bits. If the top
//   two bits differ -> clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) by sign of the ACC_W+1 bit
//   and set frame sat flag. Saturation is clamp-and-continue: later terms add to the clamped
//   value. Frame sat flag transfers to sat with acc_out.
//  clr: highest priority after rst. Next edge -> state=ACCUM, acc=0, count=0, out_valid=0,
//   sat=0, acc_out=0. A product presented with clr is dropped; a pending result is dropped.
//  NUM_TERMS=1: every accepted product goes straight to DONE (pass-through with sat).
//  rst mid-frame or mid-DONE: partial sum and pending result discarded immediately.
//  in_valid while in DONE: ignored (in_ready=0); producer must hold data.
// TESTING
//  T1 NUM_TERMS=4: products 100,-50,3,-1 back-to-back, out_ready=1 -> acc_out=52, sat=0,
//     out_valid high exactly 1 cycle, in_ready low exactly 1 cycle.
//  T2 NUM_TERMS=4, in_valid gaps of 0..3 cycles between 4 terms of -512*511 (=-261632) ->
//     acc_out=-1046528, sat=0; count advances only on handshakes.
//  T3 ACC_W=20, NUM_TERMS=2: 262144 twice -> acc_out=524287, sat=1; -524288 twice ->
//     acc_out=-524288, sat=1; next frame 1,1 -> acc_out=2, sat=0.
//  T4 Backpressure: out_ready=0 for 10 cycles after completion -> acc_out/sat stable,
//     in_ready=0, further in_valid ignored; out_ready=1 -> release, next frame sums fresh.
//  T5 clr after 2 of 4 terms, then 4 terms of 7 -> acc_out=28 (partial sum discarded);
//     clr while in DONE -> out_valid drops next edge, no handshake occurs.
//  T6 rst pulse asserted between edges mid-frame -> outputs reset without a clock edge;
//     after release, 4 terms of 1 -> acc_out=4.

Source files
------------

// File: rtl/signed_prod_accum.sv
// Sums NUM_TERMS signed products from the multiplier into one saturated frame result,
// handed to the consumer over a valid/ready handshake.
module signed_prod_accum #(
  parameter int PROD_W    = 20,
  parameter int ACC_W     = 24,
  parameter int NUM_TERMS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic signed [PROD_W-1:0] prod_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sat
);

  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DONE  = 1'b1;

  // The extra top bit of the sum disagrees with the sign bit exactly when it overflowed.
  function automatic logic sat_ovf(input logic signed [ACC_W:0] s);
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  logic [0:0]              state;
  logic signed [ACC_W-1:0] acc_p1;
  logic [CNT_W-1:0]        cnt_p1;
  logic                    frame_sat_p1;

  logic signed [ACC_W:0]   prod_ext;
  logic signed [ACC_W:0]   sum_p0;
  logic signed [ACC_W-1:0] sum_sat_p0;
  logic                    ovf_p0;
  logic                    accept;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Stage p0: widened sum of running total and incoming product, then clamp.
  assign prod_ext   = {{(ACC_W + 1 - PROD_W){prod_in[PROD_W-1]}}, prod_in};
  assign sum_p0     = {acc_p1[ACC_W-1], acc_p1} + prod_ext;
  assign ovf_p0     = sat_ovf(sum_p0);
  assign sum_sat_p0 = sat_clamp(sum_p0);

  // Stage p1: running total, term count and frame result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      acc_p1       <= '0;
      cnt_p1       <= '0;
      frame_sat_p1 <= 1'b0;
      acc_out      <= '0;
      sat          <= 1'b0;
    end else if (clr) begin
      state        <= ACCUM;
      acc_p1       <= '0;
      cnt_p1       <= '0;
      frame_sat_p1 <= 1'b0;
      acc_out      <= '0;
      sat          <= 1'b0;
    end else if (state == ACCUM) begin
      if (accept) begin
        if (cnt_p1 == LAST_CNT) begin
          acc_out      <= sum_sat_p0;
          sat          <= frame_sat_p1 | ovf_p0;
          acc_p1       <= '0;
          cnt_p1       <= '0;
          frame_sat_p1 <= 1'b0;
          state        <= DONE;
        end else begin
          acc_p1       <= sum_sat_p0;
          cnt_p1       <= cnt_p1 + 1'b1;
          frame_sat_p1 <= frame_sat_p1 | ovf_p0;
        end
      end
    end else begin
      if (out_ready) begin
        sat   <= 1'b0;
        state <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_signed_prod_accum.sv
// Directed bench for signed_prod_accum: a 4-term/24-bit instance, a 2-term/20-bit
// saturating instance and a 1-term pass-through instance.
module tb_signed_prod_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic               a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sat;
  logic signed [19:0] a_prod;
  logic signed [23:0] a_acc;

  logic               b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sat;
  logic signed [19:0] b_prod;
  logic signed [19:0] b_acc;

  logic               c_clr, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_sat;
  logic signed [19:0] c_prod;
  logic signed [19:0] c_acc;

  signed_prod_accum #(.PROD_W(20), .ACC_W(24), .NUM_TERMS(4)) u_a (
    .clk(clk), .rst(rst), .clr(a_clr), .prod_in(a_prod), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .acc_out(a_acc), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sat(a_sat));

  signed_prod_accum #(.PROD_W(20), .ACC_W(20), .NUM_TERMS(2)) u_b (
    .clk(clk), .rst(rst), .clr(b_clr), .prod_in(b_prod), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .acc_out(b_acc), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sat(b_sat));

  signed_prod_accum #(.PROD_W(20), .ACC_W(20), .NUM_TERMS(1)) u_c (
    .clk(clk), .rst(rst), .clr(c_clr), .prod_in(c_prod), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .acc_out(c_acc), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .sat(c_sat));

  typedef struct packed {
    logic [3:0][19:0] p;
    logic [3:0][1:0]  g;
    int               exp;
  } vec_t;

  vec_t vecs [6];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input int p0, input int p1, input int p2, input int p3,
                              input int g0, input int g1, input int g2, input int g3,
                              input int e);
    vec_t v;
    v.p[0] = 20'(p0); v.p[1] = 20'(p1); v.p[2] = 20'(p2); v.p[3] = 20'(p3);
    v.g[0] = 2'(g0);  v.g[1] = 2'(g1);  v.g[2] = 2'(g2);  v.g[3] = 2'(g3);
    v.exp  = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [3:0][19:0] p, input logic [3:0][1:0] g, input string tag);
    for (int k = 0; k < 4; k++) begin
      a_in_valid = 1'b0;
      repeat (int'(g[k])) step();
      a_in_valid = 1'b1;
      a_prod     = p[k];
      step();
      a_in_valid = 1'b0;
      if (k < 3) chk($sformatf("%s pending%0d", tag, k), a_out_valid, 0);
    end
  endtask

  task automatic expect_a(input string tag, input int exp, input logic s);
    chk($sformatf("%s out_valid", tag), a_out_valid, 1);
    chk($sformatf("%s acc_out", tag), a_acc, exp);
    chk($sformatf("%s sat", tag), s, a_sat);
    chk($sformatf("%s in_ready", tag), a_in_ready, 0);
  endtask

  task automatic send_b(input int p0, input int p1, input int exp, input logic s, input string tag);
    b_in_valid = 1'b1;
    b_prod     = 20'(p0);
    step();
    chk($sformatf("%s pending", tag), b_out_valid, 0);
    b_prod = 20'(p1);
    step();
    b_in_valid = 1'b0;
    chk($sformatf("%s out_valid", tag), b_out_valid, 1);
    chk($sformatf("%s acc_out", tag), b_acc, exp);
    chk($sformatf("%s sat", tag), b_sat, s);
    step();
    chk($sformatf("%s released", tag), b_out_valid, 0);
    chk($sformatf("%s sat cleared", tag), b_sat, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(100, -50, 3, -1, 0, 0, 0, 0, 52);
    vecs[1] = mk(-261632, -261632, -261632, -261632, 0, 1, 2, 3, -1046528);
    vecs[2] = mk(524287, 524287, 524287, 524287, 0, 0, 0, 0, 2097148);
    vecs[3] = mk(-524288, -524288, -524288, -524288, 3, 0, 2, 1, -2097152);
    vecs[4] = mk(1, -1, 1, -1, 1, 0, 0, 1, 0);
    vecs[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0;
    a_clr = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_prod = '0;
    b_clr = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_prod = '0;
    c_clr = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_prod = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset in_ready", a_in_ready, 1);
    chk("reset out_valid", a_out_valid, 0);
    chk("reset acc_out", a_acc, 0);
    chk("reset sat", a_sat, 0);
    #20 rst = 1'b0;
    step();

    // Back-to-back and gapped frames with the consumer always ready.
    a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_a(vecs[i].p, vecs[i].g, $sformatf("vec%0d", i));
      expect_a($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
      step();
      chk($sformatf("vec%0d out_valid 1cyc", i), a_out_valid, 0);
      chk($sformatf("vec%0d in_ready back", i), a_in_ready, 1);
    end

    // Saturation in a 20-bit accumulator, then a clean frame.
    b_out_ready = 1'b1;
    send_b(262144, 262144, 524287, 1'b1, "sat_pos");
    send_b(-524288, -524288, -524288, 1'b1, "sat_neg");
    send_b(1, 1, 2, 1'b0, "fresh");
    send_b(524287, -1, 524286, 1'b0, "near_max");

    // Single-term pass-through.
    c_in_valid = 1'b1;
    c_prod     = -20'sd7;
    step();
    c_in_valid = 1'b0;
    chk("pt out_valid", c_out_valid, 1);
    chk("pt acc_out", c_acc, -7);
    chk("pt in_ready", c_in_ready, 0);
    step();
    chk("pt held", c_out_valid, 1);
    c_out_ready = 1'b1;
    step();
    chk("pt released", c_out_valid, 0);
    c_in_valid = 1'b1;
    c_prod     = -20'sd524288;
    step();
    c_in_valid = 1'b0;
    chk("pt min acc_out", c_acc, -524288);
    chk("pt min sat", c_sat, 0);
    step();

    // Backpressure: result held, new products ignored.
    a_out_ready = 1'b0;
    send_a(mk(5, 5, 5, 5, 0, 0, 0, 0, 0).p, '0, "bp");
    expect_a("bp", 20, 1'b0);
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1;
      a_prod     = 20'sd1000;
      step();
      expect_a($sformatf("bp hold%0d", i), 20, 1'b0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    chk("bp released", a_out_valid, 0);
    chk("bp in_ready", a_in_ready, 1);
    send_a(mk(1, 2, 3, 4, 0, 0, 0, 0, 0).p, '0, "bp_next");
    expect_a("bp_next", 10, 1'b0);
    step();

    // clr mid-frame drops the partial sum and the product presented with it.
    a_in_valid = 1'b1;
    a_prod     = 20'sd50;
    step();
    step();
    a_prod = 20'sd999;
    a_clr  = 1'b1;
    step();
    a_clr      = 1'b0;
    a_in_valid = 1'b0;
    chk("clr mid in_ready", a_in_ready, 1);
    a_out_ready = 1'b0;
    send_a(mk(7, 7, 7, 7, 0, 0, 0, 0, 0).p, '0, "clr_frame");
    expect_a("clr_frame", 28, 1'b0);
    // clr while the result is pending drops it.
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    chk("clr done out_valid", a_out_valid, 0);
    chk("clr done acc_out", a_acc, 0);
    chk("clr done in_ready", a_in_ready, 1);
    a_out_ready = 1'b1;
    send_a(mk(1, 1, 1, 1, 0, 0, 0, 0, 0).p, '0, "after_clr");
    expect_a("after_clr", 4, 1'b0);
    step();

    // Async reset mid-frame, applied between clock edges.
    a_in_valid = 1'b1;
    a_prod     = 20'sd9;
    step();
    step();
    a_in_valid = 1'b0;
    #3 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    a_out_ready = 1'b0;
    send_a(mk(1, 1, 1, 1, 0, 0, 0, 0, 0).p, '0, "rst_mid");
    expect_a("rst_mid", 4, 1'b0);
    // Async reset while the result is pending, observed before any edge.
    #3 rst = 1'b1;
    #1;
    chk("rst done out_valid", a_out_valid, 0);
    chk("rst done acc_out", a_acc, 0);
    chk("rst done in_ready", a_in_ready, 1);
    #1 rst = 1'b0;
    step();
    a_out_ready = 1'b1;
    send_a(mk(2, 2, 2, 2, 0, 0, 0, 0, 0).p, '0, "after_rst");
    expect_a("after_rst", 8, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
